// File: rtl/snow64_ext_data_responder.sv
// Target-side endpoint of the CPU external data access bus.
// Accepts one line-sized request at a time, holds busy for LATENCY cycles,
// then commits a write to the backing line RAM or returns read data.
module snow64_ext_data_responder #(
  parameter int LOG2_DEPTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_req,
  input  logic         in_access_type,
  input  logic [63:0]  in_addr,
  input  logic [255:0] in_data,
  output logic         out_busy,
  output logic [255:0] out_data,
  output logic         out_addr_err,
  output logic         out_proto_err
);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("snow64_ext_data_responder: LATENCY must be in 1..255");
  end

  localparam int unsigned DEPTH  = 2 ** LOG2_DEPTH;
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t state;
  state_t next_state;

  logic [255:0]          mem [DEPTH];
  logic [7:0]            count;
  logic                  lat_write;
  logic                  lat_in_range;
  logic [LOG2_DEPTH-1:0] lat_idx;
  logic [255:0]          lat_data;

  logic                  accept;
  logic                  complete;
  logic                  req_while_busy;
  logic                  req_in_range;
  logic [LOG2_DEPTH-1:0] req_idx;

  // Line index ignores the byte offset within the 32-byte line.
  assign req_idx      = in_addr[5 +: LOG2_DEPTH];
  assign req_in_range = (in_addr >> (5 + LOG2_DEPTH)) == 64'd0;
  assign out_busy     = (state == ST_BUSY);

  // Next-state and per-cycle event decode.
  always_comb begin
    next_state     = state;
    accept         = 1'b0;
    complete       = 1'b0;
    req_while_busy = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_req) begin
          accept     = 1'b1;
          next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        req_while_busy = in_req;
        if (count == 8'd0) begin
          complete   = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request latching, latency counter, read return and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      lat_write     <= 1'b0;
      lat_in_range  <= 1'b0;
      lat_idx       <= '0;
      lat_data      <= '0;
      out_data      <= '0;
      out_addr_err  <= 1'b0;
      out_proto_err <= 1'b0;
    end else begin
      if (accept) begin
        lat_write    <= in_access_type;
        lat_in_range <= req_in_range;
        lat_idx      <= req_idx;
        lat_data     <= in_data;
        count        <= LAT_M1;
        if (!req_in_range) begin
          out_addr_err <= 1'b1;
        end
      end else if (state == ST_BUSY && count != 8'd0) begin
        count <= count - 8'd1;
      end
      if (complete && !lat_write) begin
        out_data <= lat_in_range ? mem[lat_idx] : '0;
      end
      if (req_while_busy) begin
        out_proto_err <= 1'b1;
      end
    end
  end

  // Backing line RAM; contents survive reset, pending writes do not.
  always_ff @(posedge clk) begin
    if (!rst && complete && lat_write && lat_in_range) begin
      mem[lat_idx] <= lat_data;
    end
  end

endmodule
